// File: rtl/hilo_unit_pkg.sv
// Shared definitions for the HI/LO register block: bus widths, R-type funct
// codes for the HI/LO instructions and the tracking FSM state encoding.
package hilo_unit_pkg;

   localparam int unsigned DATA_BUS       = 32;
   localparam int unsigned MULT_DIV_BUS   = 64;
   localparam int unsigned FUNCT_BUS      = 6;
   localparam int unsigned HILO_STATE_BUS = 2;

   localparam logic [FUNCT_BUS-1:0] FUNCT_MFHI  = 6'b010000;
   localparam logic [FUNCT_BUS-1:0] FUNCT_MTHI  = 6'b010001;
   localparam logic [FUNCT_BUS-1:0] FUNCT_MFLO  = 6'b010010;
   localparam logic [FUNCT_BUS-1:0] FUNCT_MTLO  = 6'b010011;
   localparam logic [FUNCT_BUS-1:0] FUNCT_MULT  = 6'b011000;
   localparam logic [FUNCT_BUS-1:0] FUNCT_MULTU = 6'b011001;
   localparam logic [FUNCT_BUS-1:0] FUNCT_DIV   = 6'b011010;
   localparam logic [FUNCT_BUS-1:0] FUNCT_DIVU  = 6'b011011;

   typedef enum logic [HILO_STATE_BUS-1:0] {
      HILO_IDLE = 2'd0,
      HILO_WAIT = 2'd1,
      HILO_HOLD = 2'd2
   } hilo_state_t;

   function automatic logic is_mult_div(input logic [FUNCT_BUS-1:0] f);
      return (f == FUNCT_MULT) || (f == FUNCT_MULTU) ||
             (f == FUNCT_DIV)  || (f == FUNCT_DIVU);
   endfunction

endpackage

// File: rtl/hilo_unit_slot.sv
// hilo_slot: one pipeline register carrying a pending HI/LO write.
// Ports: clk/rst; clear kills the entry (wins over hold); hold keeps the
// current entry; otherwise d_* is loaded. q_* is the registered entry.
module hilo_slot
   import hilo_unit_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                clear,
   input  logic                hold,
   input  logic                d_valid,
   input  logic                d_hi_we,
   input  logic                d_lo_we,
   input  logic [DATA_BUS-1:0] d_hi,
   input  logic [DATA_BUS-1:0] d_lo,
   output logic                q_valid,
   output logic                q_hi_we,
   output logic                q_lo_we,
   output logic [DATA_BUS-1:0] q_hi,
   output logic [DATA_BUS-1:0] q_lo
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q_valid <= 1'b0;
         q_hi_we <= 1'b0;
         q_lo_we <= 1'b0;
         q_hi    <= '0;
         q_lo    <= '0;
      end else if (clear) begin
         q_valid <= 1'b0;
         q_hi_we <= 1'b0;
         q_lo_we <= 1'b0;
         q_hi    <= '0;
         q_lo    <= '0;
      end else if (!hold) begin
         q_valid <= d_valid;
         q_hi_we <= d_hi_we;
         q_lo_we <= d_lo_we;
         q_hi    <= d_hi;
         q_lo    <= d_lo;
      end
   end

endmodule

// File: rtl/hilo_unit.sv
// hilo_unit: HI/LO architectural registers for the EX stage.
// Ports: clk, rst (async, active-high); flush kills EX/MEM state; stall_all
// freezes the pipeline; funct/mt_data describe the EX instruction; md_done/
// md_result is the mult/div completion interface. Outputs: stall_req holds
// EX while a mult/div is in flight, read_data is the forwarded MFHI/MFLO
// value, hi/lo are the architectural registers.
module hilo_unit
   import hilo_unit_pkg::*;
#(
   parameter logic [DATA_BUS-1:0] kResetValue = 32'h0
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    flush,
   input  logic                    stall_all,
   input  logic [FUNCT_BUS-1:0]    funct,
   input  logic [DATA_BUS-1:0]     mt_data,
   input  logic                    md_done,
   input  logic [MULT_DIV_BUS-1:0] md_result,
   output logic                    stall_req,
   output logic [DATA_BUS-1:0]     read_data,
   output logic [DATA_BUS-1:0]     hi,
   output logic [DATA_BUS-1:0]     lo
);

   hilo_state_t state, state_nxt;
   logic [MULT_DIV_BUS-1:0] hold_buf;
   logic                    latch_hold;

   logic                push_valid, push_hi_we, push_lo_we;
   logic [DATA_BUS-1:0] push_hi, push_lo;

   logic                mem_valid, mem_hi_we, mem_lo_we;
   logic [DATA_BUS-1:0] mem_hi, mem_lo;
   logic                wb_valid, wb_hi_we, wb_lo_we;
   logic [DATA_BUS-1:0] wb_hi, wb_lo;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= HILO_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      stall_req  = 1'b0;
      latch_hold = 1'b0;
      push_valid = 1'b0;
      push_hi_we = 1'b0;
      push_lo_we = 1'b0;
      push_hi    = '0;
      push_lo    = '0;
      case (state)
         HILO_IDLE: begin
            if (!flush && is_mult_div(funct)) begin
               // A done pulse in the issue cycle completes immediately.
               stall_req = !md_done;
               if (!md_done) begin
                  state_nxt = HILO_WAIT;
               end else if (!stall_all) begin
                  push_valid = 1'b1;
                  push_hi_we = 1'b1;
                  push_lo_we = 1'b1;
                  {push_hi, push_lo} = md_result;
               end else begin
                  latch_hold = 1'b1;
                  state_nxt  = HILO_HOLD;
               end
            end else if (!flush && !stall_all &&
                         (funct == FUNCT_MTHI || funct == FUNCT_MTLO)) begin
               push_valid = 1'b1;
               push_hi_we = (funct == FUNCT_MTHI);
               push_lo_we = (funct == FUNCT_MTLO);
               push_hi    = mt_data;
               push_lo    = mt_data;
            end
         end
         HILO_WAIT: begin
            stall_req = !md_done;
            if (!flush && md_done) begin
               if (!stall_all) begin
                  push_valid = 1'b1;
                  push_hi_we = 1'b1;
                  push_lo_we = 1'b1;
                  {push_hi, push_lo} = md_result;
                  state_nxt  = HILO_IDLE;
               end else begin
                  latch_hold = 1'b1;
                  state_nxt  = HILO_HOLD;
               end
            end
         end
         HILO_HOLD: begin
            if (!flush && !stall_all) begin
               push_valid = 1'b1;
               push_hi_we = 1'b1;
               push_lo_we = 1'b1;
               {push_hi, push_lo} = hold_buf;
               state_nxt  = HILO_IDLE;
            end
         end
         default: state_nxt = HILO_IDLE;
      endcase
      if (flush) state_nxt = HILO_IDLE;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)             hold_buf <= '0;
      else if (flush)      hold_buf <= '0;
      else if (latch_hold) hold_buf <= md_result;
   end

   hilo_slot u_mem (
      .clk(clk), .rst(rst), .clear(flush), .hold(stall_all),
      .d_valid(push_valid), .d_hi_we(push_hi_we), .d_lo_we(push_lo_we),
      .d_hi(push_hi), .d_lo(push_lo),
      .q_valid(mem_valid), .q_hi_we(mem_hi_we), .q_lo_we(mem_lo_we),
      .q_hi(mem_hi), .q_lo(mem_lo)
   );

   hilo_slot u_wb (
      .clk(clk), .rst(rst), .clear(flush), .hold(stall_all),
      .d_valid(mem_valid), .d_hi_we(mem_hi_we), .d_lo_we(mem_lo_we),
      .d_hi(mem_hi), .d_lo(mem_lo),
      .q_valid(wb_valid), .q_hi_we(wb_hi_we), .q_lo_we(wb_lo_we),
      .q_hi(wb_hi), .q_lo(wb_lo)
   );

   // The register write is taken on the edge that moves MEM into WB, so a
   // result is architecturally visible two unstalled edges after issue and
   // is already committed by the time a flush could reach the WB slot.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hi <= kResetValue;
         lo <= kResetValue;
      end else if (!flush && !stall_all && mem_valid) begin
         if (mem_hi_we) hi <= mem_hi;
         if (mem_lo_we) lo <= mem_lo;
      end
   end

   logic [DATA_BUS-1:0] fwd_hi, fwd_lo;

   always_comb begin
      fwd_hi = hi;
      fwd_lo = lo;
      if (mem_valid && mem_hi_we)     fwd_hi = mem_hi;
      else if (wb_valid && wb_hi_we)  fwd_hi = wb_hi;
      if (mem_valid && mem_lo_we)     fwd_lo = mem_lo;
      else if (wb_valid && wb_lo_we)  fwd_lo = wb_lo;
      read_data = '0;
      if (funct == FUNCT_MFHI)      read_data = fwd_hi;
      else if (funct == FUNCT_MFLO) read_data = fwd_lo;
   end

endmodule
